// File: rtl/draw_request_scheduler_pkg.sv
// Shared draw package: FSM state encoding, screen constants and the
// request entry layout used by the scheduler and the sprite drawer.
package draw_request_scheduler_pkg;

   localparam int DRAW_X_ORIGIN    = 32;
   localparam int DRAW_LANE_PITCH  = 64;
   localparam int DRAW_Y_MAX_START = 180;
   localparam int DRAW_SPRITE_SIZE = 60;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      LAUNCH    = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4
   } drawState_t;

   typedef struct packed {
      logic [1:0] lane;
      logic [7:0] y;
      logic       erase;
   } drawReq_t;

   localparam int DRAW_REQ_WIDTH = $bits(drawReq_t);

   // Lane number to sprite-origin x, kept to the 9-bit screen width
   function automatic logic [8:0] laneToX(input logic [1:0] lane, input int origin, input int pitch);
      int x;
      x = origin + int'(lane) * pitch;
      return x[8:0];
   endfunction

   // Keep the sprite fully on screen by limiting its origin y
   function automatic logic [7:0] clampY(input logic [7:0] y, input int yMax);
      logic [7:0] result;
      if (int'(y) > yMax) begin
         result = yMax[7:0];
      end else begin
         result = y;
      end
      return result;
   endfunction

endpackage

// File: rtl/draw_request_scheduler_if.sv
// Request handshake plus drawer control signals. The scheduler takes the
// slave view; whoever offers requests and models the drawer takes master.
interface draw_request_scheduler_if;

   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_lane;
   logic [7:0]  req_y;
   logic        req_erase;
   logic        shapeDone;
   logic        startingAddressLoaded;
   logic [8:0]  startX;
   logic [7:0]  startY;
   logic        eraseMode;
   logic        busy;
   logic [15:0] shapesDrawn;

   modport master (
      output req_valid, req_lane, req_y, req_erase, shapeDone,
      input  req_ready, startingAddressLoaded, startX, startY, eraseMode, busy, shapesDrawn
   );

   modport slave (
      input  req_valid, req_lane, req_y, req_erase, shapeDone,
      output req_ready, startingAddressLoaded, startX, startY, eraseMode, busy, shapesDrawn
   );

endinterface

// File: rtl/draw_request_scheduler_fifo.sv
// Small synchronous FIFO holding pending draw requests. Pointers carry one
// extra wrap bit so full and empty can be told apart without a counter.
module req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PtrOne = (AW + 1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wrPtr_q, wrPtr_d;
   logic [AW:0]      rdPtr_q, rdPtr_d;
   logic             doPush;
   logic             doPop;

   assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign empty_o = (wrPtr_q == rdPtr_q);
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;
   assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

   // Advance each pointer only when its side of the transfer really happens
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (doPush) begin
         wrPtr_d = wrPtr_q + PtrOne;
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + PtrOne;
      end
   end

   // Pointer registers; clearing them is enough to empty the FIFO
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Storage needs no reset since stale slots are never read while empty
   always_ff @(posedge clock) begin
      if (doPush) begin
         mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/draw_request_scheduler.sv
// Queues sprite draw/erase requests and hands them one at a time to the
// sprite drawer using a start pulse and the drawer's shapeDone handshake.
module draw_request_scheduler
   import draw_request_scheduler_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int X_ORIGIN    = DRAW_X_ORIGIN,
   parameter int LANE_PITCH  = DRAW_LANE_PITCH,
   parameter int Y_MAX_START = DRAW_Y_MAX_START
) (
   input logic                     clock,
   input logic                     resetn,
   draw_request_scheduler_if.slave bus
);

   drawState_t                state_q, state_d;
   logic [8:0]                startX_q, startX_d;
   logic [7:0]                startY_q, startY_d;
   logic                      eraseMode_q, eraseMode_d;
   logic [15:0]               shapesDrawn_q, shapesDrawn_d;
   logic                      fifoFull;
   logic                      fifoEmpty;
   logic                      fifoPop;
   logic [DRAW_REQ_WIDTH-1:0] fifoRdata;
   drawReq_t                  fifoHead;

   assign fifoHead = fifoRdata;

   req_fifo #(
      .WIDTH (DRAW_REQ_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .resetn  (resetn),
      .push_i  (bus.req_valid),
      .pop_i   (fifoPop),
      .wdata_i ({bus.req_lane, bus.req_y, bus.req_erase}),
      .rdata_o (fifoRdata),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   assign bus.req_ready             = !fifoFull;
   assign bus.startingAddressLoaded = (state_q == LAUNCH);
   assign bus.busy                  = (state_q != IDLE) || !fifoEmpty;
   assign bus.startX                = startX_q;
   assign bus.startY                = startY_q;
   assign bus.eraseMode             = eraseMode_q;
   assign bus.shapesDrawn           = shapesDrawn_q;

   // Next-state logic: start only when the drawer reports idle, latch the
   // sprite origin while popping, then follow shapeDone falling and rising
   always_comb begin
      state_d       = state_q;
      startX_d      = startX_q;
      startY_d      = startY_q;
      eraseMode_d   = eraseMode_q;
      shapesDrawn_d = shapesDrawn_q;
      fifoPop       = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifoEmpty && bus.shapeDone) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            fifoPop     = 1'b1;
            startX_d    = laneToX(fifoHead.lane, X_ORIGIN, LANE_PITCH);
            startY_d    = clampY(fifoHead.y, Y_MAX_START);
            eraseMode_d = fifoHead.erase;
            state_d     = LAUNCH;
         end
         LAUNCH: begin
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!bus.shapeDone) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (bus.shapeDone) begin
               if (shapesDrawn_q != 16'hFFFF) begin
                  shapesDrawn_d = shapesDrawn_q + 16'd1;
               end
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight request
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         startX_q      <= '0;
         startY_q      <= '0;
         eraseMode_q   <= 1'b0;
         shapesDrawn_q <= '0;
      end else begin
         state_q       <= state_d;
         startX_q      <= startX_d;
         startY_q      <= startY_d;
         eraseMode_q   <= eraseMode_d;
         shapesDrawn_q <= shapesDrawn_d;
      end
   end

endmodule

// File: tb/tb_draw_request_scheduler.sv
// Bench for draw_request_scheduler: a drawer model answers start pulses,
// and every accepted request queues its expected sprite origin, which is
// compared when the matching start pulse appears.
module tb_draw_request_scheduler;
   import draw_request_scheduler_pkg::*;

   typedef struct {
      logic [8:0] x;
      logic [7:0] y;
      logic       e;
   } expPulse_t;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   int          errors = 0;
   int          checks = 0;
   int          pulseCount = 0;
   expPulse_t   expQ[$];
   expPulse_t   monExp;
   logic        manualMode = 1'b0;
   logic        manualLevel = 1'b1;
   int          drawCycles = 10;
   int          drawCnt = 0;
   logic [15:0] expDrawn = 16'd0;

   draw_request_scheduler_if bus();

   draw_request_scheduler #(
      .DEPTH       (4),
      .X_ORIGIN    (32),
      .LANE_PITCH  (64),
      .Y_MAX_START (180)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   // Free-running clock, 10 time units per period
   always #5 clock = ~clock;

   function automatic logic [8:0] modelX(input int lane);
      int v;
      v = 32 + lane * 64;
      return v[8:0];
   endfunction

   function automatic logic [7:0] modelY(input int y);
      int v;
      v = (y > 180) ? 180 : y;
      return v[7:0];
   endfunction

   // Drawer model: drops shapeDone after a start pulse and raises it again
   // drawCycles later, or follows manualLevel when a test steers it
   always @(negedge clock or negedge resetn) begin
      if (!resetn) begin
         drawCnt = 0;
         bus.shapeDone = 1'b1;
      end else if (manualMode) begin
         bus.shapeDone = manualLevel;
      end else if (bus.startingAddressLoaded === 1'b1) begin
         bus.shapeDone = 1'b0;
         drawCnt = drawCycles;
      end else if (drawCnt > 0) begin
         drawCnt--;
         if (drawCnt == 0) bus.shapeDone = 1'b1;
      end
   end

   // Scoreboard: each start pulse must match the oldest outstanding request
   always @(negedge clock) begin
      if (bus.startingAddressLoaded === 1'b1) begin
         pulseCount++;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_pulse: got a start pulse, required none");
         end else begin
            monExp = expQ.pop_front();
            checks += 3;
            if (bus.startX !== monExp.x) begin
               errors++;
               $display("[TB] FAIL pulse_startX: got %0d, required %0d", bus.startX, monExp.x);
            end
            if (bus.startY !== monExp.y) begin
               errors++;
               $display("[TB] FAIL pulse_startY: got %0d, required %0d", bus.startY, monExp.y);
            end
            if (bus.eraseMode !== monExp.e) begin
               errors++;
               $display("[TB] FAIL pulse_eraseMode: got %b, required %b", bus.eraseMode, monExp.e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Offer one request for one edge; its expected pulse is queued if accepted
   task automatic applyStimulus(input int lane, input int y, input logic erase, output logic accepted);
      bus.req_lane  = lane[1:0];
      bus.req_y     = y[7:0];
      bus.req_erase = erase;
      bus.req_valid = 1'b1;
      accepted = bus.req_ready;
      if (accepted === 1'b1) expQ.push_back('{x: modelX(lane), y: modelY(y), e: erase});
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic waitIdle(input string tag, input int budget);
      int n;
      n = 0;
      while ((bus.busy !== 1'b0 || expQ.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (bus.busy !== 1'b0 || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s_idle: got busy=%b pending=%0d after %0d cycles, required busy=0 pending=0",
                  tag, bus.busy, expQ.size(), n);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks += 6;
      if (bus.startingAddressLoaded !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse: got %b, required 0", bus.startingAddressLoaded); end
      if (bus.startX !== 9'd0) begin errors++; $display("[TB] FAIL reset_startX: got %0d, required 0", bus.startX); end
      if (bus.startY !== 8'd0) begin errors++; $display("[TB] FAIL reset_startY: got %0d, required 0", bus.startY); end
      if (bus.eraseMode !== 1'b0) begin errors++; $display("[TB] FAIL reset_eraseMode: got %b, required 0", bus.eraseMode); end
      if (bus.shapesDrawn !== 16'd0) begin errors++; $display("[TB] FAIL reset_shapesDrawn: got %0d, required 0", bus.shapesDrawn); end
      if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", bus.busy); end
      @(negedge clock);
      resetn = 1'b1;
      tick();
      checks++;
      if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b, required 1", bus.req_ready); end
   endtask

   task automatic test_single();
      logic acc;
      int edges;
      drawCycles = 10;
      applyStimulus(2, 50, 1'b0, acc);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("[TB] FAIL single_accept: got ready=%b, required 1", acc); end
      edges = 1;
      while (bus.startingAddressLoaded !== 1'b1 && edges < 12) begin
         tick();
         edges++;
      end
      checks++;
      if (edges != 3) begin errors++; $display("[TB] FAIL single_latency: got %0d edges, required 3", edges); end
      waitIdle("single", 60);
      expDrawn = expDrawn + 16'd1;
      checks++;
      if (bus.shapesDrawn !== expDrawn) begin errors++; $display("[TB] FAIL single_count: got %0d, required %0d", bus.shapesDrawn, expDrawn); end
   endtask

   task automatic test_back_to_back();
      logic acc;
      int base;
      int n;
      int lanes[4] = '{0, 1, 2, 3};
      int ys[4] = '{10, 20, 30, 40};
      drawCycles = 4;
      manualLevel = 1'b0;
      manualMode = 1'b1;
      @(negedge clock);
      tick();
      base = pulseCount;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(lanes[i], ys[i], i[0], acc);
         checks++;
         if (acc !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept%0d: got ready=%b, required 1", i, acc); end
      end
      bus.req_lane = 2'd1;
      bus.req_y = 8'd200;
      bus.req_erase = 1'b1;
      bus.req_valid = 1'b1;
      checks++;
      if (bus.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_ready: got %b, required 0", bus.req_ready); end
      repeat (3) tick();
      checks += 2;
      if (pulseCount != base) begin errors++; $display("[TB] FAIL idle_wait_pulses: got %0d, required %0d", pulseCount, base); end
      if (bus.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_wait_ready: got %b, required 0", bus.req_ready); end
      manualLevel = 1'b1;
      @(negedge clock);
      #1;
      manualMode = 1'b0;
      n = 0;
      acc = 1'b0;
      while (acc !== 1'b1 && n < 20) begin
         if (bus.req_ready === 1'b1) begin
            expQ.push_back('{x: modelX(1), y: modelY(200), e: 1'b1});
            acc = 1'b1;
         end
         tick();
         n++;
      end
      bus.req_valid = 1'b0;
      checks++;
      if (acc !== 1'b1) begin errors++; $display("[TB] FAIL b2b_fifth_accept: got ready=%b after %0d cycles, required 1", bus.req_ready, n); end
      waitIdle("b2b", 200);
      expDrawn = expDrawn + 16'd5;
      checks += 2;
      if (pulseCount != base + 5) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d, required %0d", pulseCount - base, 5); end
      if (bus.shapesDrawn !== expDrawn) begin errors++; $display("[TB] FAIL b2b_count: got %0d, required %0d", bus.shapesDrawn, expDrawn); end
   endtask

   task automatic test_clamp();
      logic acc;
      int lanes[4] = '{0, 3, 1, 2};
      int ys[4] = '{255, 180, 181, 200};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(lanes[i], ys[i], ~i[0], acc);
         checks++;
         if (acc !== 1'b1) begin errors++; $display("[TB] FAIL clamp_accept%0d: got ready=%b, required 1", i, acc); end
      end
      waitIdle("clamp", 150);
      expDrawn = expDrawn + 16'd4;
      checks += 3;
      if (bus.shapesDrawn !== expDrawn) begin errors++; $display("[TB] FAIL clamp_count: got %0d, required %0d", bus.shapesDrawn, expDrawn); end
      if (bus.startX !== modelX(2)) begin errors++; $display("[TB] FAIL hold_startX: got %0d, required %0d", bus.startX, modelX(2)); end
      if (bus.startY !== modelY(200)) begin errors++; $display("[TB] FAIL hold_startY: got %0d, required %0d", bus.startY, modelY(200)); end
   endtask

   task automatic test_stall();
      logic acc;
      int base;
      int n;
      manualLevel = 1'b1;
      manualMode = 1'b1;
      base = pulseCount;
      applyStimulus(2, 77, 1'b1, acc);
      applyStimulus(3, 10, 1'b0, acc);
      n = 0;
      while (pulseCount == base && n < 10) begin
         tick();
         n++;
      end
      repeat (5) tick();
      checks += 3;
      if (pulseCount != base + 1) begin errors++; $display("[TB] FAIL stall_pulses: got %0d, required 1", pulseCount - base); end
      if (dut.state_q !== WAIT_BUSY) begin errors++; $display("[TB] FAIL stall_state: got %0d, required %0d", dut.state_q, WAIT_BUSY); end
      if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_busy: got %b, required 1", bus.busy); end
      manualLevel = 1'b0;
      repeat (2) tick();
      checks++;
      if (bus.shapesDrawn !== expDrawn) begin errors++; $display("[TB] FAIL stall_early_count: got %0d, required %0d", bus.shapesDrawn, expDrawn); end
      manualLevel = 1'b1;
      @(negedge clock);
      #1;
      manualMode = 1'b0;
      waitIdle("stall", 100);
      expDrawn = expDrawn + 16'd2;
      checks++;
      if (bus.shapesDrawn !== expDrawn) begin errors++; $display("[TB] FAIL stall_count: got %0d, required %0d", bus.shapesDrawn, expDrawn); end
   endtask

   task automatic test_reset_mid();
      logic acc;
      int base;
      int n;
      drawCycles = 20;
      base = pulseCount;
      applyStimulus(1, 60, 1'b0, acc);
      applyStimulus(2, 70, 1'b1, acc);
      applyStimulus(3, 80, 1'b0, acc);
      n = 0;
      while (pulseCount == base && n < 10) begin
         tick();
         n++;
      end
      repeat (3) tick();
      checks++;
      if (dut.state_q !== WAIT_DONE) begin errors++; $display("[TB] FAIL midreset_setup_state: got %0d, required %0d", dut.state_q, WAIT_DONE); end
      #2;
      resetn = 1'b0;
      #1;
      checks += 6;
      if (bus.startingAddressLoaded !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pulse: got %b, required 0", bus.startingAddressLoaded); end
      if (bus.startX !== 9'd0) begin errors++; $display("[TB] FAIL midreset_startX: got %0d, required 0", bus.startX); end
      if (bus.startY !== 8'd0) begin errors++; $display("[TB] FAIL midreset_startY: got %0d, required 0", bus.startY); end
      if (bus.eraseMode !== 1'b0) begin errors++; $display("[TB] FAIL midreset_eraseMode: got %b, required 0", bus.eraseMode); end
      if (bus.shapesDrawn !== 16'd0) begin errors++; $display("[TB] FAIL midreset_shapesDrawn: got %0d, required 0", bus.shapesDrawn); end
      if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b, required 0", bus.busy); end
      expQ.delete();
      expDrawn = 16'd0;
      @(negedge clock);
      resetn = 1'b1;
      repeat (10) tick();
      checks += 3;
      if (pulseCount != base + 1) begin errors++; $display("[TB] FAIL midreset_no_pulse: got %0d pulses, required 1", pulseCount - base); end
      if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_after_busy: got %b, required 0", bus.busy); end
      if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_after_ready: got %b, required 1", bus.req_ready); end
   endtask

   task automatic test_saturation();
      logic acc;
      drawCycles = 4;
      force dut.shapesDrawn_q = 16'hFFFE;
      @(negedge clock);
      release dut.shapesDrawn_q;
      tick();
      checks++;
      if (bus.shapesDrawn !== 16'hFFFE) begin errors++; $display("[TB] FAIL sat_preload: got %h, required fffe", bus.shapesDrawn); end
      applyStimulus(0, 5, 1'b0, acc);
      applyStimulus(1, 6, 1'b1, acc);
      waitIdle("sat", 100);
      checks++;
      if (bus.shapesDrawn !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_reach: got %h, required ffff", bus.shapesDrawn); end
      applyStimulus(3, 7, 1'b0, acc);
      waitIdle("sat_hold", 100);
      checks++;
      if (bus.shapesDrawn !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_hold: got %h, required ffff", bus.shapesDrawn); end
   endtask

   // Test sequence
   initial begin
      bus.req_valid = 1'b0;
      bus.req_lane  = 2'd0;
      bus.req_y     = 8'd0;
      bus.req_erase = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_clamp();
      test_stall();
      test_reset_mid();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Last-resort guard so a stuck run still ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/draw_request_scheduler.md
DRAW_REQUEST_SCHEDULER -- requirements
Module: draw_request_scheduler

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DEPTH, 4, request FIFO entries (power of two).
- X_ORIGIN, 32, x of lane 0 sprite origin.
- LANE_PITCH, 64, x spacing between lanes.
- Y_MAX_START, 180, largest legal sprite-origin y.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock, in, 1, sole clock, rising edge.
- resetn, in, 1, asynchronous active-low reset.
- req_valid, in, 1, draw request offered.
- req_ready, out, 1, scheduler can accept a request.
- req_lane, in, 2, note lane 0..3.
- req_y, in, 8, requested sprite-origin y.
- req_erase, in, 1, 1 = erase sprite, 0 = draw it.
- shapeDone, in, 1, drawer idle, high when it can start.
- startingAddressLoaded, out, 1, one-cycle start pulse to the drawer.
- startX, out, 9, sprite origin x.
- startY, out, 8, sprite origin y.
- eraseMode, out, 1, colour select for the drawer.
- busy, out, 1, scheduler not in IDLE or FIFO not empty.
- shapesDrawn, out, 16, count of completed shapes, saturating.

Function
REQ-003 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; req_ready SHALL equal "FIFO not full".
REQ-004 When the FIFO is full, req_ready SHALL be 0 even if a pop occurs in the same cycle; a simultaneous push and pop on a non-full FIFO SHALL both take effect.
REQ-005 Each FIFO entry SHALL store {lane, y, erase}, and entries SHALL issue in arrival order.
REQ-006 The FSM SHALL have five states:
- IDLE: exit to LOAD when the FIFO is not empty and shapeDone=1; otherwise stay.
- LOAD: pop the FIFO head and register startX, startY and eraseMode; always go to LAUNCH.
- LAUNCH: drive startingAddressLoaded=1 for exactly this cycle; always go to WAIT_BUSY.
- WAIT_BUSY: go to WAIT_DONE when shapeDone=0; otherwise stay.
- WAIT_DONE: when shapeDone=1, increment shapesDrawn and go to IDLE; otherwise stay.
REQ-007 startX SHALL equal X_ORIGIN + lane*LANE_PITCH, computed in 9 bits (lane 3 gives 224).
REQ-008 startY SHALL equal min(req_y, Y_MAX_START), so req_y=200 yields 180.
REQ-009 startX, startY and eraseMode SHALL hold their values from LOAD until the next LOAD.
REQ-010 startingAddressLoaded SHALL be asserted in no state other than LAUNCH.
REQ-011 shapesDrawn SHALL saturate at 16'hFFFF.
REQ-012 busy SHALL be 1 whenever the state is not IDLE or the FIFO is not empty.
REQ-013 The minimum time from push into an empty FIFO to the start pulse SHALL be 3 cycles (push edge, IDLE->LOAD, LOAD->LAUNCH).
REQ-014 If shapeDone=0 in IDLE, for example after a drawer reset, the FSM SHALL wait in IDLE and SHALL NOT pop.

Reset
REQ-015 While resetn=0, the following SHALL hold asynchronously:
- state = IDLE and FIFO empty;
- req_ready=1 after release;
- startingAddressLoaded=0, startX=0, startY=0, eraseMode=0, shapesDrawn=0, busy=0.
REQ-016 Reset asserted mid-draw SHALL discard all queued and in-flight requests without emitting a start pulse.

Structure
REQ-017 The state encoding and the screen constants (X_ORIGIN, LANE_PITCH, Y_MAX_START, sprite size 60) SHALL live in a shared draw package used by the drawer and this block.
REQ-018 The FIFO SHALL be a separate sub-module named req_fifo (parameterised on width and depth, with full and empty flags).

Verification
REQ-019 Single request: push lane=2, y=50 with the drawer model drawing for 10 cycles -> start pulse 3 cycles after the push, startX=160, startY=50, shapesDrawn=1 after shapeDone returns high.
REQ-020 Back-to-back: push 5 requests on consecutive cycles with DEPTH=4 -> req_ready=0 on the 5th, exactly 4 start pulses issued in order, then the 5th accepted once space frees.
REQ-021 Clamp: push y=255, lane=0 -> startX=32, startY=180.
REQ-022 Handshake stall: hold shapeDone=1 for 5 cycles after the pulse -> FSM stays in WAIT_BUSY, no second pulse, no pop.
REQ-023 Reset mid-draw: assert resetn=0 during WAIT_DONE with 2 entries queued -> all outputs zero, FIFO empty, no pulse after release.
REQ-024 Saturation: preload shapesDrawn to 16'hFFFE via 2 further completions -> counter reads 16'hFFFF and holds.
